// File: rtl/char_pkg.sv
// Shared character constants and helpers for the feeder and the begin/end
// checker, so both stages agree on what a space and a letter are.
package char_pkg;

  localparam logic [7:0] CHAR_SPACE   = 8'h20;
  localparam logic [7:0] CHAR_UPPER_A = 8'h41;
  localparam logic [7:0] CHAR_UPPER_Z = 8'h5A;
  localparam logic [7:0] CASE_BIT     = 8'h20;

  // Map 'A'..'Z' onto 'a'..'z'; every other code passes through untouched.
  function automatic logic [7:0] to_lower(input logic [7:0] c);
    logic [7:0] result;
    result = c;
    if ((c >= CHAR_UPPER_A) && (c <= CHAR_UPPER_Z)) begin
      result = c | CASE_BIT;
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock byte FIFO with extra-MSB pointers.
// Full and empty fall out of a pointer compare, and the occupancy is the
// pointer difference. The head entry is read combinationally.
module sync_fifo #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en_i,
  input  logic [7:0]  wr_data_i,
  input  logic        rd_en_i,
  output logic [7:0]  rd_data_o,
  output logic        full_o,
  output logic        empty_o,
  output logic [AW:0] level_o
);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_write;
  logic        do_read;

  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign level_o   = wr_ptr_q - rd_ptr_q;
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  assign do_write  = wr_en_i && !full_o;
  assign do_read   = rd_en_i && !empty_o;

  // Next pointer values: each advances by one on its own operation.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_write) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_read)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers; the async clear empties the FIFO at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; stale entries are never visible once empty.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

endmodule

// File: rtl/char_stream_feeder.sv
// Front end for the begin/end checker: lowercases letters, collapses runs
// of spaces to one, and buffers the result in a sync_fifo.
// Optional word counter enabled by defining CHAR_STREAM_FEEDER_WORDCOUNT_EN.
module char_stream_feeder
  import char_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [AW:0] level
`ifdef CHAR_STREAM_FEEDER_WORDCOUNT_EN
  ,
  output logic [15:0] word_count
`endif
);

  logic       fifo_full;
  logic       fifo_empty;
  logic       accept;
  logic       pop;
  logic       is_space;
  logic       write;
  logic [7:0] norm_char;
  logic       last_space_q, last_space_d;

  assign in_ready  = !fifo_full;
  assign out_valid = !fifo_empty;
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign is_space  = (in_data == CHAR_SPACE);
  assign norm_char = to_lower(in_data);
  // A space directly after another space (or after reset) is swallowed.
  assign write     = accept && !(is_space && last_space_q);

  // Remember whether the last accepted character was a space.
  always_comb begin
    last_space_d = last_space_q;
    if (accept) last_space_d = is_space;
  end

  // Reset to "just saw a space" so leading spaces never reach the FIFO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_space_q <= 1'b1;
    else        last_space_q <= last_space_d;
  end

  sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (write),
    .wr_data_i (norm_char),
    .rd_en_i   (pop),
    .rd_data_o (out_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (level)
  );

`ifdef CHAR_STREAM_FEEDER_WORDCOUNT_EN
  logic [15:0] word_count_q, word_count_d;

  // A word starts on a non-space arriving after a space; stop at all-ones.
  always_comb begin
    word_count_d = word_count_q;
    if (accept && !is_space && last_space_q && (word_count_q != 16'hFFFF)) begin
      word_count_d = word_count_q + 16'd1;
    end
  end

  // Word counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) word_count_q <= '0;
    else        word_count_q <= word_count_d;
  end

  assign word_count = word_count_q;
`endif

endmodule
